cpu_sequencer: RTL and testbench

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

---
 rtl/cpu_sequencer.sv | 171 +++++++++++++++++
 tb/tb_cpu_sequencer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// Multi-cycle CPU control sequencer: steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB and owns the PC, retire counter and halt flags.
module cpu_sequencer (
  input  logic        clk,
  input  logic        rstd,
  input  logic        run,
  input  logic        halt_req,
  input  logic [5:0]  op,
  input  logic [31:0] nextpc,
  input  logic        dm_ready,
  output logic [31:0] pc,
  output logic        ir_we,
  output logic        reg_we,
  output logic        dm_we,
  output logic [2:0]  state,
  output logic        halted,
  output logic        illegal,
  output logic [31:0] instret
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    C_ALU,
    C_LOAD,
    C_STORE,
    C_BRANCH,
    C_JUMP,
    C_JAL,
    C_STOP,
    C_ILLEGAL
  } op_class_e;

  function automatic op_class_e decode_op(input logic [5:0] opcode);
    op_class_e cls;
    case (opcode)
      6'd0, 6'd1, 6'd3, 6'd4, 6'd5, 6'd6: cls = C_ALU;
      6'd16, 6'd18, 6'd20:                 cls = C_LOAD;
      6'd24, 6'd26, 6'd28:                 cls = C_STORE;
      6'd32, 6'd33, 6'd34, 6'd35:          cls = C_BRANCH;
      6'd40, 6'd42:                        cls = C_JUMP;
      6'd41:                               cls = C_JAL;
      6'd63:                               cls = C_STOP;
      default:                             cls = C_ILLEGAL;
    endcase
    return cls;
  endfunction

  state_e      state_q, state_d;
  op_class_e   cls_q, cls_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instret_q, instret_d;
  logic        halted_q, halted_d;
  logic        illegal_q, illegal_d;
  logic        boundary;
  op_class_e   op_cls;

  assign op_cls = decode_op(op);

  // NOTE: every variable written here gets a default first, so no path
  // through the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    cls_d     = cls_q;
    pc_d      = pc_q;
    instret_d = instret_q;
    halted_d  = halted_q;
    illegal_d = illegal_q;
    boundary  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (run && !halt_req) state_d = S_FETCH;
      end
      S_FETCH: begin
        state_d = S_DECODE;
      end
      S_DECODE: begin
        cls_d = op_cls;
        if (op_cls == C_STOP) begin
          state_d  = S_HALT;
          halted_d = 1'b1;
        end else if (op_cls == C_ILLEGAL) begin
          state_d   = S_HALT;
          halted_d  = 1'b1;
          illegal_d = 1'b1;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (cls_q == C_LOAD || cls_q == C_STORE) state_d = S_MEM;
        else                                     state_d = S_WB;
      end
      S_MEM: begin
        if (dm_ready) begin
          if (cls_q == C_LOAD) state_d  = S_WB;
          else                 boundary = 1'b1;
        end
      end
      S_WB: begin
        boundary = 1'b1;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        // Unreachable encoding 7: park safely and flag it.
        state_d   = S_HALT;
        halted_d  = 1'b1;
        illegal_d = 1'b1;
      end
    endcase

    // Run/halt requests are only honoured here, after the instruction retires.
    if (boundary) begin
      pc_d      = nextpc;
      instret_d = instret_q + 32'd1;
      if (halt_req) begin
        state_d  = S_HALT;
        halted_d = 1'b1;
      end else if (!run) begin
        state_d = S_IDLE;
      end else begin
        state_d = S_FETCH;
      end
    end
  end

  // NOTE: reset is synchronous (sampled on the clock edge) and all state
  // updates use non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rstd) begin
      state_q   <= S_IDLE;
      cls_q     <= C_ILLEGAL;
      pc_q      <= 32'd0;
      instret_q <= 32'd0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      pc_q      <= pc_d;
      instret_q <= instret_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
    end
  end

  // Strobes depend only on registered state and class, so they are
  // glitch-free and mutually exclusive by construction.
  assign ir_we  = (state_q == S_FETCH);
  assign reg_we = (state_q == S_WB) &&
                  (cls_q == C_ALU || cls_q == C_LOAD || cls_q == C_JAL);
  assign dm_we  = (state_q == S_MEM) && (cls_q == C_STORE);

  assign pc      = pc_q;
  assign state   = state_q;
  assign halted  = halted_q;
  assign illegal = illegal_q;
  assign instret = instret_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: per-cycle expectations are queued as
// stimulus is applied and compared after the following clock edge.
module tb_cpu_sequencer;

  localparam logic [2:0] IDLE = 3'd0, FETCH = 3'd1, DECODE = 3'd2, EXEC = 3'd3,
                         MEM = 3'd4, WB = 3'd5, HALT = 3'd6;
  // Strobe patterns as {ir_we, reg_we, dm_we}
  localparam logic [2:0] NONE = 3'b000, IRW = 3'b100, RGW = 3'b010, DMW = 3'b001;

  logic        clk = 1'b0;
  logic        rstd = 1'b0;
  logic        run = 1'b0;
  logic        halt_req = 1'b0;
  logic [5:0]  op = 6'd0;
  logic [31:0] nextpc = 32'd0;
  logic        dm_ready = 1'b0;
  logic [31:0] pc;
  logic        ir_we, reg_we, dm_we;
  logic [2:0]  state;
  logic        halted, illegal;
  logic [31:0] instret;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [2:0]  st;
    logic [2:0]  strb;
    logic [31:0] pc;
    logic [31:0] ir;
    logic        h;
    logic        il;
  } exp_t;

  exp_t sb[$];

  cpu_sequencer dut (
    .clk      (clk),
    .rstd     (rstd),
    .run      (run),
    .halt_req (halt_req),
    .op       (op),
    .nextpc   (nextpc),
    .dm_ready (dm_ready),
    .pc       (pc),
    .ir_we    (ir_we),
    .reg_we   (reg_we),
    .dm_we    (dm_we),
    .state    (state),
    .halted   (halted),
    .illegal  (illegal),
    .instret  (instret)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Inputs are already applied (at a falling edge); queue what the outputs
  // must be after the next rising edge, then move to the next falling edge.
  task automatic step(input string tag, input logic [2:0] st, input logic [2:0] strb,
                      input logic [31:0] epc, input logic [31:0] eir,
                      input logic eh, input logic eil);
    exp_t e;
    e.tag = tag; e.st = st; e.strb = strb; e.pc = epc; e.ir = eir; e.h = eh; e.il = eil;
    sb.push_back(e);
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({e.tag, "/state"},   {29'd0, state}, {29'd0, e.st});
      check({e.tag, "/strobes"}, {29'd0, ir_we, reg_we, dm_we}, {29'd0, e.strb});
      check({e.tag, "/pc"},      pc, e.pc);
      check({e.tag, "/instret"}, instret, e.ir);
      check({e.tag, "/halted"},  {31'd0, halted}, {31'd0, e.h});
      check({e.tag, "/illegal"}, {31'd0, illegal}, {31'd0, e.il});
    end
  end

  initial begin
    // Reset state
    rstd = 1'b0; run = 1'b0;
    step("rst0", IDLE, NONE, 0, 0, 0, 0);
    step("rst1", IDLE, NONE, 0, 0, 0, 0);

    // ALU op 0: ir_we cycle 1, reg_we cycle 4, FETCH again cycle 5
    rstd = 1'b1; run = 1'b1; op = 6'd0; nextpc = 32'd1;
    step("alu_f", FETCH, IRW, 0, 0, 0, 0);
    step("alu_d", DECODE, NONE, 0, 0, 0, 0);
    step("alu_e", EXEC, NONE, 0, 0, 0, 0);
    step("alu_w", WB, RGW, 0, 0, 0, 0);
    step("alu_nf", FETCH, IRW, 1, 1, 0, 0);

    // Load with two wait cycles: MEM x3, 7 cycles total
    op = 6'd16; nextpc = 32'd2; dm_ready = 1'b0;
    step("ld_d", DECODE, NONE, 1, 1, 0, 0);
    step("ld_e", EXEC, NONE, 1, 1, 0, 0);
    step("ld_m1", MEM, NONE, 1, 1, 0, 0);
    step("ld_m2", MEM, NONE, 1, 1, 0, 0);
    step("ld_m3", MEM, NONE, 1, 1, 0, 0);
    dm_ready = 1'b1;
    step("ld_w", WB, RGW, 1, 1, 0, 0);
    step("ld_nf", FETCH, IRW, 2, 2, 0, 0);

    // Store with immediate ready: one dm_we cycle, no reg_we
    op = 6'd24; nextpc = 32'd3;
    step("st_d", DECODE, NONE, 2, 2, 0, 0);
    step("st_e", EXEC, NONE, 2, 2, 0, 0);
    step("st_m", MEM, DMW, 2, 2, 0, 0);
    step("st_nf", FETCH, IRW, 3, 3, 0, 0);

    // jal writes the register file, plain jump does not
    op = 6'd41; nextpc = 32'h40;
    step("jal_d", DECODE, NONE, 3, 3, 0, 0);
    step("jal_e", EXEC, NONE, 3, 3, 0, 0);
    step("jal_w", WB, RGW, 3, 3, 0, 0);
    step("jal_nf", FETCH, IRW, 32'h40, 4, 0, 0);
    op = 6'd40; nextpc = 32'h44;
    step("j_d", DECODE, NONE, 32'h40, 4, 0, 0);
    step("j_e", EXEC, NONE, 32'h40, 4, 0, 0);
    step("j_w", WB, NONE, 32'h40, 4, 0, 0);
    step("j_nf", FETCH, IRW, 32'h44, 5, 0, 0);

    // Branch with halt_req raised during EXEC: retires, then HALT
    op = 6'd32; nextpc = 32'h48;
    step("br_d", DECODE, NONE, 32'h44, 5, 0, 0);
    step("br_e", EXEC, NONE, 32'h44, 5, 0, 0);
    halt_req = 1'b1;
    step("br_w", WB, NONE, 32'h44, 5, 0, 0);
    step("br_halt", HALT, NONE, 32'h48, 6, 1, 0);
    halt_req = 1'b0; run = 1'b0;
    step("halt_r0", HALT, NONE, 32'h48, 6, 1, 0);
    run = 1'b1;
    step("halt_r1", HALT, NONE, 32'h48, 6, 1, 0);
    run = 1'b0;
    step("halt_r2", HALT, NONE, 32'h48, 6, 1, 0);

    // run dropped mid-instruction: completes, then IDLE; IDLE ignores run while halt_req
    rstd = 1'b0;
    step("rst2", IDLE, NONE, 0, 0, 0, 0);
    rstd = 1'b1; run = 1'b1; op = 6'd1; nextpc = 32'h20;
    step("r0_f", FETCH, IRW, 0, 0, 0, 0);
    run = 1'b0;
    step("r0_d", DECODE, NONE, 0, 0, 0, 0);
    step("r0_e", EXEC, NONE, 0, 0, 0, 0);
    step("r0_w", WB, RGW, 0, 0, 0, 0);
    step("r0_idle", IDLE, NONE, 32'h20, 1, 0, 0);
    run = 1'b1; halt_req = 1'b1;
    step("idle_hr", IDLE, NONE, 32'h20, 1, 0, 0);
    halt_req = 1'b0; op = 6'd63;
    step("stop_f", FETCH, IRW, 32'h20, 1, 0, 0);
    step("stop_d", DECODE, NONE, 32'h20, 1, 0, 0);
    step("stop_h", HALT, NONE, 32'h20, 1, 1, 0);

    // Illegal opcode 7: HALT from DECODE, pc/instret untouched
    rstd = 1'b0;
    step("rst3", IDLE, NONE, 0, 0, 0, 0);
    rstd = 1'b1; op = 6'd7; nextpc = 32'h9;
    step("il_f", FETCH, IRW, 0, 0, 0, 0);
    step("il_d", DECODE, NONE, 0, 0, 0, 0);
    step("il_h", HALT, NONE, 0, 0, 1, 1);
    step("il_h2", HALT, NONE, 0, 0, 1, 1);

    // Reset while a store waits in MEM
    rstd = 1'b0;
    step("rst4", IDLE, NONE, 0, 0, 0, 0);
    rstd = 1'b1; op = 6'd0; nextpc = 32'h10;
    step("pre_f", FETCH, IRW, 0, 0, 0, 0);
    step("pre_d", DECODE, NONE, 0, 0, 0, 0);
    step("pre_e", EXEC, NONE, 0, 0, 0, 0);
    step("pre_w", WB, RGW, 0, 0, 0, 0);
    step("pre_nf", FETCH, IRW, 32'h10, 1, 0, 0);
    op = 6'd26; nextpc = 32'h14; dm_ready = 1'b0;
    step("mr_d", DECODE, NONE, 32'h10, 1, 0, 0);
    step("mr_e", EXEC, NONE, 32'h10, 1, 0, 0);
    step("mr_m1", MEM, DMW, 32'h10, 1, 0, 0);
    step("mr_m2", MEM, DMW, 32'h10, 1, 0, 0);
    rstd = 1'b0;
    step("mr_rst", IDLE, NONE, 0, 0, 0, 0);
    rstd = 1'b1; run = 1'b0;
    step("mr_after", IDLE, NONE, 0, 0, 0, 0);

    // Bounded drain of the scoreboard
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
